reg_scoreboard: RTL and testbench

Register-file scoreboard and issue controller for the pipelined core. Tracks which architectural registers have a write in flight, and holds the decode stage while a source or destination register is pending. Clears pending state when the writeback stage drives the register file's two write ports. Sits between decode and the register file: decode presents an instruction, and `reg_scoreboard` decides each cycle whether it may issue.

---
 rtl/reg_scoreboard.sv | 106 ++++++++++
 tb/tb_reg_scoreboard.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register scoreboard and issue controller (optional REG_SCOREBOARD_WB_BYPASS_EN)
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_valid,
  input  logic          dec_ren0,
  input  logic          dec_ren1,
  input  logic [AW-1:0] dec_raddr0,
  input  logic [AW-1:0] dec_raddr1,
  input  logic          dec_wen0,
  input  logic [AW-1:0] dec_waddr0,
  input  logic          dec_wen1,
  input  logic [AW-1:0] dec_waddr1,
  input  logic          pipe_stall,
  input  logic          wb_wen0,
  input  logic [AW-1:0] wb_waddr0,
  input  logic          wb_wen1,
  input  logic [AW-1:0] wb_waddr1,
  output logic             hazard,
  output logic             issue,
  output logic [NREGS-1:0] pending,
  output logic [AW:0]      busy_count,
  output logic             idle,
  output logic             wb_err
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [AW:0]      busy_count_q, busy_count_d;
  logic             wb_err_q, wb_err_d;

  logic [NREGS-1:0] src_mask;
  logic [NREGS-1:0] dst_mask;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] chk_mask;

  // One-hot of an enabled register address; r0 never produces a bit so it
  // can neither stall decode nor become pending.
  function automatic logic [NREGS-1:0] reg_mask(input logic en, input logic [AW-1:0] addr);
    logic [NREGS-1:0] m;
    m = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (en && (addr == AW'(i))) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Decode operand masks, writeback clear mask and the mask hazards are checked against.
  always_comb begin
    dst_mask = reg_mask(dec_wen0, dec_waddr0) | reg_mask(dec_wen1, dec_waddr1);
    // Destinations are included so a WAW on an in-flight register stalls too.
    src_mask = reg_mask(dec_ren0, dec_raddr0) | reg_mask(dec_ren1, dec_raddr1) | dst_mask;
    // Equal writeback addresses collapse into a single bit, i.e. one clear.
    clr_mask = reg_mask(wb_wen0, wb_waddr0) | reg_mask(wb_wen1, wb_waddr1);
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    // Forwarding lets an operand being written back this cycle be consumed now.
    chk_mask = pending_q & ~clr_mask;
`else
    chk_mask = pending_q;
`endif
  end

  // Issue decision; a stalled pipe blocks issue but not the hazard report.
  always_comb begin
    hazard   = dec_valid & (|(src_mask & chk_mask));
    issue    = dec_valid & ~hazard & ~pipe_stall;
    set_mask = issue ? dst_mask : '0;
  end

  // Next pending vector: set wins over a clear of the same register.
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | set_mask;
    // A clear of a non-pending register is a writeback protocol error.
    wb_err_d  = wb_err_q | (|(clr_mask & ~pending_q));
  end

  // Population count of the next pending vector, registered alongside it.
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_count_d = busy_count_d + {{AW{1'b0}}, pending_d[i]};
    end
  end

  // State registers; reset wipes all in-flight tracking and the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      busy_count_q <= '0;
      wb_err_q     <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      busy_count_q <= busy_count_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign pending    = pending_q;
  assign busy_count = busy_count_q;
  assign idle       = (busy_count_q == '0);
  assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - randomized self-checking bench for reg_scoreboard
module tb_reg_scoreboard;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          dec_valid, dec_ren0, dec_ren1, dec_wen0, dec_wen1;
  logic [AW-1:0] dec_raddr0, dec_raddr1, dec_waddr0, dec_waddr1;
  logic          pipe_stall;
  logic          wb_wen0, wb_wen1;
  logic [AW-1:0] wb_waddr0, wb_waddr1;
  logic             hazard, issue, idle, wb_err;
  logic [NREGS-1:0] pending;
  logic [AW:0]      busy_count;

  reg_scoreboard #(.NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ren0(dec_ren0), .dec_ren1(dec_ren1),
    .dec_raddr0(dec_raddr0), .dec_raddr1(dec_raddr1),
    .dec_wen0(dec_wen0), .dec_waddr0(dec_waddr0),
    .dec_wen1(dec_wen1), .dec_waddr1(dec_waddr1),
    .pipe_stall(pipe_stall),
    .wb_wen0(wb_wen0), .wb_waddr0(wb_waddr0),
    .wb_wen1(wb_wen1), .wb_waddr1(wb_waddr1),
    .hazard(hazard), .issue(issue), .pending(pending),
    .busy_count(busy_count), .idle(idle), .wb_err(wb_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: one flag per architectural register plus the sticky error.
  bit m_pend [NREGS];
  bit m_err;
  bit last_issue;

  function automatic bit wb_hits(input int r);
    if (r == 0) return 1'b0;
    return (wb_wen0 && wb_waddr0 == AW'(r)) || (wb_wen1 && wb_waddr1 == AW'(r));
  endfunction

  function automatic bit blocked(input logic en, input logic [AW-1:0] a);
    if (!en || a == 0) return 1'b0;
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    return m_pend[a] && !wb_hits(int'(a));
`else
    return m_pend[a];
`endif
  endfunction

  task automatic cycle();
    bit exp_h, exp_i;
    bit np [NREGS];
    bit ne;
    logic [NREGS-1:0] exp_vec;
    int cnt;
    @(negedge clk);
    exp_h = dec_valid && (blocked(dec_ren0, dec_raddr0) || blocked(dec_ren1, dec_raddr1) ||
                          blocked(dec_wen0, dec_waddr0) || blocked(dec_wen1, dec_waddr1));
    exp_i = dec_valid && !exp_h && !pipe_stall;
    cnt = 0;
    exp_vec = '0;
    for (int r = 0; r < NREGS; r++) begin
      exp_vec[r] = m_pend[r];
      if (m_pend[r]) cnt++;
    end
    check("hazard", 64'(hazard), 64'(exp_h));
    check("issue", 64'(issue), 64'(exp_i));
    check("pending", 64'(pending), 64'(exp_vec));
    check("busy_count", 64'(busy_count), 64'(cnt));
    check("idle", 64'(idle), 64'(cnt == 0));
    check("wb_err", 64'(wb_err), 64'(m_err));
    if (rst) begin
      for (int r = 0; r < NREGS; r++) np[r] = 1'b0;
      ne = 1'b0;
    end else begin
      ne = m_err;
      if (wb_wen0 && wb_waddr0 != 0 && !m_pend[wb_waddr0]) ne = 1'b1;
      if (wb_wen1 && wb_waddr1 != 0 && !m_pend[wb_waddr1]) ne = 1'b1;
      for (int r = 0; r < NREGS; r++) np[r] = m_pend[r] && !wb_hits(r);
      if (exp_i && dec_wen0 && dec_waddr0 != 0) np[dec_waddr0] = 1'b1;
      if (exp_i && dec_wen1 && dec_waddr1 != 0) np[dec_waddr1] = 1'b1;
    end
    last_issue = exp_i;
    @(posedge clk);
    #1;
    m_pend = np;
    m_err  = ne;
  endtask

  task automatic set_dec(input logic v, input logic r0e, input int r0, input logic r1e, input int r1,
                         input logic w0e, input int w0, input logic w1e, input int w1);
    dec_valid = v;
    dec_ren0 = r0e; dec_raddr0 = AW'(r0);
    dec_ren1 = r1e; dec_raddr1 = AW'(r1);
    dec_wen0 = w0e; dec_waddr0 = AW'(w0);
    dec_wen1 = w1e; dec_waddr1 = AW'(w1);
  endtask

  task automatic set_wb(input logic e0, input int a0, input logic e1, input int a1);
    wb_wen0 = e0; wb_waddr0 = AW'(a0);
    wb_wen1 = e1; wb_waddr1 = AW'(a1);
  endtask

  task automatic quiet();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0, 0);
    pipe_stall = 1'b0;
    rst = 1'b0;
  endtask

  function automatic int pick_wb_addr();
    int start;
    if ($urandom_range(0, 39) == 0) return int'($urandom_range(0, NREGS - 1));
    start = int'($urandom_range(1, NREGS - 1));
    for (int k = 0; k < NREGS - 1; k++) begin
      if (m_pend[1 + ((start - 1 + k) % (NREGS - 1))]) return 1 + ((start - 1 + k) % (NREGS - 1));
    end
    return 0;
  endfunction

  logic [NREGS-1:0] snap;

  initial begin
    quiet();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int r = 0; r < NREGS; r++) m_pend[r] = 1'b0;
    m_err = 1'b0;
    last_issue = 1'b0;
    check("reset_pending", 64'(pending), 64'(0));
    check("reset_busy", 64'(busy_count), 64'(0));
    check("reset_idle", 64'(idle), 64'(1));
    check("reset_wb_err", 64'(wb_err), 64'(0));
    cycle();

    // Write r5, then a reader of r5 must stall until writeback.
    set_dec(1, 0, 0, 0, 0, 1, 5, 0, 0);
    cycle();
    set_dec(1, 1, 5, 0, 0, 0, 0, 0, 0);
    #1;
    check("raw_hazard", 64'(hazard), 64'(1));
    check("raw_issue", 64'(issue), 64'(0));
    check("raw_pend5", 64'(pending[5]), 64'(1));
    check("raw_busy", 64'(busy_count), 64'(1));
    cycle();
    set_wb(1, 5, 0, 0);
    #1;
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    check("wb_same_cycle_issue", 64'(issue), 64'(1));
`else
    check("wb_same_cycle_issue", 64'(issue), 64'(0));
`endif
    cycle();
    set_wb(0, 0, 0, 0);
    #1;
    check("wb_next_cycle_issue", 64'(issue), 64'(1));
    check("wb_cleared_pend5", 64'(pending[5]), 64'(0));
    cycle();

    // Post-increment load: two destinations, retired together.
    set_dec(1, 1, 2, 0, 0, 1, 3, 1, 4);
    cycle();
    quiet();
    #1;
    check("pinc_pend3", 64'(pending[3]), 64'(1));
    check("pinc_pend4", 64'(pending[4]), 64'(1));
    check("pinc_busy", 64'(busy_count), 64'(2));
    set_wb(1, 3, 1, 4);
    cycle();
    quiet();
    #1;
    check("pinc_idle", 64'(idle), 64'(1));

    // Same address on both writeback ports is one clear.
    set_dec(1, 0, 0, 0, 0, 1, 7, 1, 7);
    cycle();
    quiet();
    #1;
    check("dup_set_busy", 64'(busy_count), 64'(1));
    set_wb(1, 7, 1, 7);
    cycle();
    quiet();
    #1;
    check("dup_clr_busy", 64'(busy_count), 64'(0));
    check("dup_clr_err", 64'(wb_err), 64'(0));

    // Writeback to a non-pending register raises the sticky error.
    set_wb(1, 9, 0, 0);
    cycle();
    quiet();
    cycle();
    cycle();
    check("err_sticky", 64'(wb_err), 64'(1));

    // r0 operands never stall or become pending.
    snap = pending;
    set_dec(1, 1, 0, 0, 0, 1, 0, 0, 0);
    #1;
    check("r0_hazard", 64'(hazard), 64'(0));
    check("r0_issue", 64'(issue), 64'(1));
    cycle();
    quiet();
    #1;
    check("r0_pending", 64'(pending), 64'(snap));

    // Downstream stall blocks issue and set.
    set_dec(1, 0, 0, 0, 0, 1, 10, 0, 0);
    pipe_stall = 1'b1;
    #1;
    check("stall_issue", 64'(issue), 64'(0));
    cycle();
    quiet();
    #1;
    check("stall_pend10", 64'(pending[10]), 64'(0));

    // Reset mid-operation clears pending state and the error.
    set_dec(1, 0, 0, 0, 0, 1, 12, 0, 0);
    cycle();
    quiet();
    rst = 1'b1;
    cycle();
    quiet();
    #1;
    check("midrst_pending", 64'(pending), 64'(0));
    check("midrst_err", 64'(wb_err), 64'(0));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if (!(dec_valid && !last_issue)) begin
        set_dec($urandom_range(0, 3) != 0,
                1'($urandom), int'($urandom_range(0, 7)),
                1'($urandom), int'($urandom_range(0, 7)),
                1'($urandom), int'($urandom_range(0, 7)),
                $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)));
      end
      wb_wen0 = 1'($urandom);
      wb_waddr0 = AW'(pick_wb_addr());
      wb_wen1 = $urandom_range(0, 2) == 0;
      wb_waddr1 = ($urandom_range(0, 5) == 0) ? wb_waddr0 : AW'(pick_wb_addr());
      pipe_stall = $urandom_range(0, 4) == 0;
      rst = $urandom_range(0, 499) == 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
